alu_sequencer: RTL and testbench

Multi-cycle issue/capture controller that acts as the initiator for the combinational ALU. It accepts one operation request over a valid/ready handshake and drives the ALU's `opcode`/`A`/`B` inputs from registers. It waits a per-class settle time, because mul/div are multi-cycle paths, then captures the 64-bit ALU result. The result goes to the register-file/HI-LO writeback side over a second valid/ready handshake, with per-half write enables.

---
 rtl/alu_sequencer.sv | 141 ++++++++++++++
 tb/tb_alu_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Issue/capture controller for the combinational ALU: latches a request, waits a settle time, returns C.
// Optional: define ALU_SEQ_DIV0_CHECK_EN to reject div with B==0 instead of issuing it.
module alu_sequencer #(
    parameter int unsigned SHORT_WAIT  = 1,
    parameter int unsigned MULDIV_WAIT = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_opcode,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [4:0]  alu_opcode,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [63:0] alu_c,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_hi,
    output logic [31:0] resp_lo,
    output logic        resp_hi_we,
    output logic        resp_lo_we,
    output logic        resp_err
);

    localparam logic [4:0] OP_FIRST = 5'b00011;
    localparam logic [4:0] OP_LAST  = 5'b10010;
    localparam logic [4:0] OP_MUL   = 5'b01111;
    localparam logic [4:0] OP_DIV   = 5'b10000;
    localparam logic [3:0] SHORT_LD  = 4'(SHORT_WAIT - 1);
    localparam logic [3:0] MULDIV_LD = 4'(MULDIV_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [4:0]  op_nx;
    logic [31:0] a_nx, b_nx, hi_nx, lo_nx;
    logic        hi_we_nx, lo_we_nx, err_nx;
    logic        legal, req_muldiv, cur_muldiv, reject;

    assign legal      = (req_opcode >= OP_FIRST) && (req_opcode <= OP_LAST);
    assign req_muldiv = (req_opcode == OP_MUL) || (req_opcode == OP_DIV);
    assign cur_muldiv = (alu_opcode == OP_MUL) || (alu_opcode == OP_DIV);

`ifdef ALU_SEQ_DIV0_CHECK_EN
    assign reject = !legal || ((req_opcode == OP_DIV) && (req_b == 32'd0));
`else
    assign reject = !legal;
`endif

    // Ready is held low while clr is asserted so nothing looks accepted in reset.
    assign req_ready  = clr && (state == IDLE);
    assign resp_valid = (state == RESP);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        op_nx    = alu_opcode;
        a_nx     = alu_a;
        b_nx     = alu_b;
        hi_nx    = resp_hi;
        lo_nx    = resp_lo;
        hi_we_nx = resp_hi_we;
        lo_we_nx = resp_lo_we;
        err_nx   = resp_err;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (reject) begin
                        err_nx   = 1'b1;
                        hi_we_nx = 1'b0;
                        lo_we_nx = 1'b0;
                        hi_nx    = 32'd0;
                        lo_nx    = 32'd0;
                        state_nx = RESP;
                    end else begin
                        op_nx    = req_opcode;
                        a_nx     = req_a;
                        b_nx     = req_b;
                        cnt_nx   = req_muldiv ? MULDIV_LD : SHORT_LD;
                        state_nx = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    hi_nx    = alu_c[63:32];
                    lo_nx    = alu_c[31:0];
                    lo_we_nx = 1'b1;
                    hi_we_nx = cur_muldiv;
                    err_nx   = 1'b0;
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    hi_we_nx = 1'b0;
                    lo_we_nx = 1'b0;
                    err_nx   = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            alu_opcode <= 5'd0;
            alu_a      <= 32'd0;
            alu_b      <= 32'd0;
            resp_hi    <= 32'd0;
            resp_lo    <= 32'd0;
            resp_hi_we <= 1'b0;
            resp_lo_we <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            alu_opcode <= op_nx;
            alu_a      <= a_nx;
            alu_b      <= b_nx;
            resp_hi    <= hi_nx;
            resp_lo    <= lo_nx;
            resp_hi_we <= hi_we_nx;
            resp_lo_we <= lo_we_nx;
            resp_err   <= err_nx;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized bench for alu_sequencer with a transaction-level reference model.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_opcode = 5'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_a, alu_b;
    logic [63:0] alu_c;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_hi, resp_lo;
    logic        resp_hi_we, resp_lo_we, resp_err;

    int n_vec = 0;
    int n_err = 0;

    logic [4:0]  last_op = 5'd0;
    logic [31:0] last_a = 32'd0;
    logic [31:0] last_b = 32'd0;

    always #5 clk = ~clk;

    // Behavioural ALU: feeds alu_c and supplies expected results.
    function automatic logic [63:0] alu_f(input logic [4:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        logic [4:0]  s;
        s = b[4:0];
        r = 32'd0;
        case (op)
            5'd3, 5'd12: r = a + b;
            5'd4:        r = a - b;
            5'd5, 5'd13: r = a & b;
            5'd6, 5'd14: r = a | b;
            5'd7:        r = a >> s;
            5'd8:        r = $signed(a) >>> s;
            5'd9:        r = a << s;
            5'd10:       r = (a >> s) | (a << (6'd32 - {1'b0, s}));
            5'd11:       r = (a << s) | (a >> (6'd32 - {1'b0, s}));
            5'd15:       return {32'd0, a} * {32'd0, b};
            5'd16:       return (b == 0) ? {a, 32'hffff_ffff} : {a % b, a / b};
            5'd17:       r = -a;
            5'd18:       r = ~a;
            default:     return 64'hdead_beef_cafe_f00d;
        endcase
        return {32'd0, r};
    endfunction

    assign alu_c = alu_f(alu_opcode, alu_a, alu_b);

    alu_sequencer dut (
        .clk        (clk),
        .clr        (clr),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c      (alu_c),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_hi    (resp_hi),
        .resp_lo    (resp_lo),
        .resp_hi_we (resp_hi_we),
        .resp_lo_we (resp_lo_we),
        .resp_err   (resp_err)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic alu_held();
        return alu_opcode === last_op && alu_a === last_a && alu_b === last_b;
    endfunction

    task automatic run_op(input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int stall);
        logic        rej, muldiv, ok, held;
        logic [63:0] exp_c;
        int          cyc, lat;
        rej    = !(op >= 5'd3 && op <= 5'd18);
        muldiv = (op == 5'd15) || (op == 5'd16);
`ifdef ALU_SEQ_DIV0_CHECK_EN
        if (op == 5'd16 && b == 32'd0) rej = 1'b1;
`endif
        lat   = rej ? 1 : (muldiv ? 4 : 1) + 1;
        exp_c = rej ? 64'd0 : alu_f(op, a, b);
        resp_ready = (stall == 0);
        @(negedge clk);
        check("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid  = 1'b1;
        req_opcode = op;
        req_a      = a;
        req_b      = b;
        @(negedge clk);
        if (!rej) begin
            last_op = op;
            last_a  = a;
            last_b  = b;
        end
        // Keep a competing request asserted; it must not be taken until IDLE.
        req_opcode = 5'd3;
        req_a      = ~a;
        req_b      = ~b;
        cyc = 1;
        ok  = 1'b1;
        while (!resp_valid && cyc < 40) begin
            ok &= alu_held() && !req_ready;
            @(negedge clk);
            cyc++;
        end
        check("latency", 64'(cyc), 64'(lat));
        check("resp_valid", {63'd0, resp_valid}, 64'd1);
        check("resp_hi", {32'd0, resp_hi}, {32'd0, exp_c[63:32]});
        check("resp_lo", {32'd0, resp_lo}, {32'd0, exp_c[31:0]});
        check("resp_we", {62'd0, resp_hi_we, resp_lo_we},
              {62'd0, !rej && muldiv, !rej});
        check("resp_err", {63'd0, resp_err}, {63'd0, rej});
        held = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            held &= resp_valid && !req_ready && resp_err == rej &&
                    resp_hi == exp_c[63:32] && resp_lo == exp_c[31:0];
        end
        check("alu_stable", {62'd0, ok, alu_held()}, 64'd3);
        check("resp_held", {63'd0, held}, 64'd1);
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("resp_done", {59'd0, resp_valid, req_ready, resp_hi_we,
                            resp_lo_we, resp_err}, 64'b01000);
        check("resp_lo_keep", {32'd0, resp_lo}, {32'd0, exp_c[31:0]});
    endtask

    task automatic reset_mid_div(input int depth);
        logic quiet;
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid  = 1'b1;
        req_opcode = 5'd16;
        req_a      = 32'd1000;
        req_b      = 32'd7;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (depth) @(negedge clk);
        clr = 1'b0;
        #1;
        check("rst_mid_out", {resp_valid, req_ready, resp_err, resp_hi_we,
                              resp_lo_we, alu_opcode, 27'd0, alu_a},
              64'd0);
        last_op = 5'd0;
        last_a  = 32'd0;
        last_b  = 32'd0;
        @(negedge clk);
        clr   = 1'b1;
        quiet = 1'b1;
        repeat (10) begin
            @(negedge clk);
            quiet &= !resp_valid;
        end
        check("rst_mid_quiet", {63'd0, quiet}, 64'd1);
        run_op(5'd3, 32'd9, 32'd4, 0);
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] a, b;
        int          r;
        clr        = 1'b0;
        req_valid  = 1'b1;
        req_opcode = 5'd3;
        req_a      = 32'd5;
        req_b      = 32'd7;
        repeat (3) @(negedge clk);
        check("rst_ready", {63'd0, req_ready}, 64'd0);
        check("rst_ctrl", {60'd0, resp_valid, resp_hi_we, resp_lo_we,
                           resp_err}, 64'd0);
        check("rst_alu_op", {59'd0, alu_opcode}, 64'd0);
        check("rst_alu_ab", {alu_a, alu_b}, 64'd0);
        check("rst_resp", {resp_hi, resp_lo}, 64'd0);
        req_valid = 1'b0;
        clr       = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {63'd0, req_ready}, 64'd1);

        run_op(5'b00011, 32'd5, 32'd7, 0);
        run_op(5'b01111, 32'h0001_0000, 32'h0001_0000, 0);
        run_op(5'b00100, 32'd3, 32'd10, 6);
        run_op(5'b11010, 32'd1, 32'd2, 0);
        run_op(5'b00000, 32'd1, 32'd2, 2);
        run_op(5'b10000, 32'd100, 32'd0, 1);
        run_op(5'b10000, 32'd100, 32'd7, 0);
        reset_mid_div(2);
        reset_mid_div(4);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) op = 5'($urandom_range(0, 31));
            else if (r < 3) op = ($urandom_range(0, 1) == 0) ? 5'd15 : 5'd16;
            else op = 5'($urandom_range(3, 18));
            a = $urandom();
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
            run_op(op, a, b, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
